// File: rtl/ppwm_pkg.sv
// -----------------------------------------------------------------------------
// ppwm_pkg
// Shared definitions for the PWM execution engine program store.
//   PPWM_INSTR_WIDTH : default instruction word width
//   PPWM_PC_WIDTH    : default program counter width (depth = 2**PC_WIDTH)
//   CMD_NOP          : all-zero instruction; returned on the fetch port
//                      whenever the image is not stable
// -----------------------------------------------------------------------------
package ppwm_pkg;

    localparam int PPWM_INSTR_WIDTH = 7;
    localparam int PPWM_PC_WIDTH    = 4;

    localparam logic [PPWM_INSTR_WIDTH-1:0] CMD_NOP = '0;

endpackage : ppwm_pkg

// File: rtl/ppwm_deser.sv
// -----------------------------------------------------------------------------
// ppwm_deser
// Bit-serial to word deserializer, MSB first.
//   clk, rst_n     : clock, synchronous active-low reset
//   clear_i        : return to an empty word (bit counter and shift register 0)
//   shift_en_i     : accept bit_i this cycle
//   bit_i          : serial data bit
//   word_o         : word formed by the held bits plus bit_i
//   word_valid_o   : high in the cycle the INSTR_WIDTH-th bit is accepted;
//                    word_o is the complete word in that cycle
// -----------------------------------------------------------------------------
module ppwm_deser
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = PPWM_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   shift_en_i,
    input  logic                   bit_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_valid_o
);

    localparam int CNT_W = (INSTR_WIDTH > 2) ? $clog2(INSTR_WIDTH) : 1;

    // Only INSTR_WIDTH-1 bits need holding: the last bit is taken straight
    // from bit_i in the cycle the word completes.
    logic [INSTR_WIDTH-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign word_o       = {shift_q, bit_i};
    assign word_valid_o = shift_en_i && (cnt_q == CNT_W'(INSTR_WIDTH - 1));

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shift_d = word_o[INSTR_WIDTH-2:0];
            cnt_d   = word_valid_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples its
    // _d value from before the edge; blocking here would create order races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : ppwm_deser

// File: rtl/ppwm_prog_store.sv
// -----------------------------------------------------------------------------
// ppwm_prog_store
// Instruction store and serial program loader for the PWM execution engine.
// A bit-serial program is deserialized into words and written in order into a
// 2**PC_WIDTH-entry flop array; the execution unit fetches combinationally.
//   clk, rst_n   : clock, synchronous active-low reset (clears the memory)
//   load_i       : load frame, high for the whole programming sequence
//   ser_valid_i  : qualifies ser_data_i for one bit
//   ser_data_i   : program bit, MSB of each word first
//   pc_i         : fetch address
//   instr_o      : mem[pc_i] when idle, CMD_NOP otherwise
//   busy_o       : high while a load is in progress or being closed
//   done_o       : one-cycle pulse after the last word has been written
// -----------------------------------------------------------------------------
module ppwm_prog_store
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = PPWM_INSTR_WIDTH,
    parameter int PC_WIDTH    = PPWM_PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   ser_valid_i,
    input  logic                   ser_data_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int DEPTH = 2 ** PC_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic                   done_q, done_d;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] mem_d [DEPTH];

    logic                   deser_clear;
    logic                   deser_shift;
    logic [INSTR_WIDTH-1:0] word;
    logic                   word_valid;

    // Bits are accepted only inside an active load frame; an abort cycle
    // (load_i low) discards its bit together with the partial word.
    assign deser_shift = (state_q == StLoad) && load_i && ser_valid_i;

    ppwm_deser #(
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (deser_clear),
        .shift_en_i   (deser_shift),
        .bit_i        (ser_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        done_d      = 1'b0;
        deser_clear = 1'b0;
        mem_d       = mem_q;

        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    state_d     = StLoad;
                    wr_addr_d   = '0;
                    deser_clear = 1'b1;
                end
            end
            StLoad: begin
                if (!load_i) begin
                    state_d = StIdle;
                end else if (word_valid) begin
                    mem_d[wr_addr_q] = word;
                    wr_addr_d        = wr_addr_q + PC_WIDTH'(1);
                    // The address wraps to 0 on the same edge that leaves
                    // StLoad, so the image is never written twice.
                    if (wr_addr_q == '1) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!load_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            // NOTE: the instruction array is reset explicitly because a
            // reset must leave a known all-NOP image, even mid-load; this is
            // why it is built from flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
            mem_q     <= mem_d;
        end
    end

    // A half-loaded image is never visible to the execution unit.
    assign instr_o = (state_q == StIdle) ? mem_q[pc_i] : INSTR_WIDTH'(CMD_NOP);
    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;

endmodule : ppwm_prog_store

// File: tb/tb_ppwm_prog_store.sv
// -----------------------------------------------------------------------------
// tb_ppwm_prog_store
// Self-checking bench for ppwm_prog_store (default parameters: 7-bit words,
// 16 entries). The driver tasks know which words they send, so the reference
// model is kept at transaction level: the committed image (ref_mem), whether
// the store should be idle, busy and pulsing done. A negedge compare process
// checks every cycle; literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_ppwm_prog_store;

    localparam int W      = 7;
    localparam int DEPTH  = 16;
    localparam int NBITS  = W * DEPTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_i;
    logic         ser_valid_i;
    logic         ser_data_i;
    logic [3:0]   pc_i;
    logic [W-1:0] instr_o;
    logic         busy_o;
    logic         done_o;

    ppwm_prog_store dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_i),
        .ser_valid_i (ser_valid_i),
        .ser_data_i  (ser_data_i),
        .pc_i        (pc_i),
        .instr_o     (instr_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #20 clk = ~clk;

    // Reference model state
    logic [W-1:0] prog    [DEPTH];
    logic [W-1:0] ref_mem [DEPTH];
    logic         exp_idle;
    logic         exp_busy;
    logic         exp_done;
    logic         chk_en;
    int           done_cnt;
    int           last_done_edge;
    int           force_pc;

    int n_tests;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the transaction-level model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_instr", instr_o, exp_idle ? ref_mem[pc_i] : '0);
            check("cyc_busy", busy_o, exp_busy);
            check("cyc_done", done_o, exp_done);
            if (done_o === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pc();
        pc_i = (force_pc >= 0) ? 4'(force_pc) : 4'($urandom);
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            pc_i = 4'(i);
            #1;
            check(name, instr_o, 0);
        end
    endtask

    task automatic sweep_mem(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            pc_i = 4'(i);
            #1;
            check(name, instr_o, ref_mem[i]);
        end
    endtask

    // Sends prog[] serially. period: 0 = random gaps, k = valid on every k-th
    // cycle. stop_bits >= 0 ends the frame after that many bits, either by
    // dropping load_i (abort) or by a one-cycle reset (load_i stays high).
    task automatic run_load(input int period, input int stop_bits, input bit stop_is_reset);
        int           sent;
        int           cyc;
        int           edges;
        int           d0;
        bit           valid;
        logic [W-1:0] cur;

        d0 = done_cnt;

        // Entry edge: a valid bit here must be ignored.
        load_i      = 1'b1;
        ser_valid_i = 1'b1;
        ser_data_i  = 1'($urandom);
        drive_pc();
        step();
        edges    = 1;
        exp_idle = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;

        sent = 0;
        cyc  = 0;
        while (sent < NBITS && sent != stop_bits) begin
            cyc++;
            drive_pc();
            valid = (period == 0) ? ($urandom_range(0, 2) != 0) : ((cyc % period) == 0);
            if (valid) begin
                cur         = prog[sent / W];
                ser_valid_i = 1'b1;
                ser_data_i  = cur[W - 1 - (sent % W)];
                sent++;
            end else begin
                ser_valid_i = 1'b0;
                ser_data_i  = 1'($urandom);
            end
            step();
            edges++;
            if (force_pc >= 0) check("load_fetch", instr_o, 0);
            if (valid && sent == NBITS) begin
                exp_done       = 1'b1;
                last_done_edge = edges;
            end
        end

        if (sent == NBITS) begin
            // StDone: serial traffic is ignored until load_i drops.
            repeat (2) begin
                ser_valid_i = 1'($urandom);
                ser_data_i  = 1'($urandom);
                drive_pc();
                step();
                exp_done = 1'b0;
            end
            load_i      = 1'b0;
            ser_valid_i = 1'b0;
            drive_pc();
            step();
            exp_idle = 1'b1;
            exp_busy = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = prog[i];
            check("done_count", done_cnt - d0, 1);
        end else if (stop_is_reset) begin
            rst_n       = 1'b0;
            ser_valid_i = 1'b0;
            step();
            rst_n    = 1'b1;
            exp_idle = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            check("done_count_rst", done_cnt - d0, 0);
        end else begin
            load_i      = 1'b0;
            ser_valid_i = 1'b0;
            drive_pc();
            step();
            exp_idle = 1'b1;
            exp_busy = 1'b0;
            for (int i = 0; i < stop_bits / W; i++) ref_mem[i] = prog[i];
            check("done_count_abort", done_cnt - d0, 0);
        end
    endtask

    task automatic random_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = W'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        done_cnt       = 0;
        last_done_edge = 0;
        force_pc       = -1;
        chk_en         = 1'b0;
        rst_n          = 1'b0;
        load_i         = 1'b0;
        ser_valid_i    = 1'b0;
        ser_data_i     = 1'b0;
        pc_i           = '0;
        exp_idle       = 1'b1;
        exp_busy       = 1'b0;
        exp_done       = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // Reset: held low for a few edges, then released.
        repeat (3) step();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        step();
        sweep_zero("rst_fetch");
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);

        // Full load 0x01..0x10, valid every cycle.
        for (int i = 0; i < DEPTH; i++) prog[i] = W'(i + 1);
        run_load(1, -1, 1'b0);
        check("done_cycle", last_done_edge, 113);
        pc_i = 4'd5;
        #1;
        check("fetch_pc5", instr_o, 7'h06);
        pc_i = 4'd15;
        #1;
        check("fetch_pc15", instr_o, 7'h10);
        sweep_mem("full_load");

        // Same image with ser_valid_i on every third cycle.
        run_load(3, -1, 1'b0);
        sweep_mem("gap3_load");
        pc_i = 4'd5;
        #1;
        check("gap3_pc5", instr_o, 7'h06);

        // Abort after 2 words and 3 bits on top of the 0x01..0x10 image.
        random_prog();
        prog[0] = 7'h7F;
        prog[1] = 7'h55;
        run_load(1, 2 * W + 3, 1'b0);
        pc_i = 4'd0;
        #1;
        check("abort_e0", instr_o, 7'h7F);
        pc_i = 4'd1;
        #1;
        check("abort_e1", instr_o, 7'h55);
        pc_i = 4'd2;
        #1;
        check("abort_e2", instr_o, 7'h03);
        sweep_mem("abort_img");

        // Fetch during load returns NOP; value visible in the first idle cycle.
        random_prog();
        prog[3]  = 7'h2A;
        force_pc = 3;
        run_load(0, -1, 1'b0);
        check("post_fetch", instr_o, 7'h2A);
        force_pc = -1;

        // Reset in the middle of word 7 with load_i still high.
        random_prog();
        run_load(1, 7 * W + 3, 1'b1);
        check("midrst_busy", busy_o, 0);
        sweep_zero("midrst_fetch");
        random_prog();
        run_load(1, -1, 1'b0);
        sweep_mem("reload_img");

        // Randomized loads, gaps and aborts.
        repeat (8) begin
            random_prog();
            run_load($urandom_range(0, 3),
                     ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, NBITS - 1)) : -1,
                     1'b0);
            sweep_mem("rand_img");
            repeat (3) begin
                pc_i = 4'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ppwm_prog_store
